// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debounce / one-shot block.
package debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    LOW_CHK  = 2'd1,
    HIGH     = 2'd2,
    HIGH_CHK = 2'd3
  } state_e;

  // Edge selection for the one-shot output.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Larger of two integers, used to size the repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_oneshot_n_channel.sv
// Single channel: synchroniser, stable-count debounce FSM, edge pulse and
// auto-repeat timer. All outputs are registered.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic os,
  output logic level,
  output logic os_repeat,
  output logic os_pre
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};
  // The accepting edge is the one whose increment would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [RPT_W-1:0] RPT_ZERO    = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_ALL1    = {RPT_W{1'b1}};
  localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);

  // With a single required cycle the CHK states are skipped entirely.
  localparam bit FAST       = (DEBOUNCE_CYCLES == 1);
  localparam bit PULSE_RISE = (EDGE_MODE != EDGE_FALL);
  localparam bit PULSE_FALL = (EDGE_MODE != EDGE_RISE);
  localparam bit REP_EN     = (REPEAT_DELAY > 0) && (EDGE_MODE != EDGE_FALL);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             rise_s;
  logic             fall_s;

  logic [RPT_W-1:0] rpt_r;
  logic [RPT_W-1:0] rpt_next_s;
  logic [RPT_W-1:0] rpt_inc_s;
  logic [RPT_W-1:0] rpt_target_s;
  logic             armed_r;
  logic             armed_next_s;
  logic             rep_pulse_s;

  logic level_next_s;
  logic os_next_s;
  logic os_repeat_next_s;
  logic level_r;
  logic os_r;
  logic os_repeat_r;

  // Shift the raw asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOW;
      cnt_r       <= CNT_ZERO;
      rpt_r       <= RPT_ZERO;
      armed_r     <= 1'b0;
      level_r     <= 1'b0;
      os_r        <= 1'b0;
      os_repeat_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      rpt_r       <= rpt_next_s;
      armed_r     <= armed_next_s;
      level_r     <= level_next_s;
      os_r        <= os_next_s;
      os_repeat_r <= os_repeat_next_s;
    end
  end

  // Debounce FSM next state, stable counter and accepted-edge events.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    cnt_inc_s    = (cnt_r == CNT_ALL1) ? cnt_r : (cnt_r + CNT_ONE);
    case (state_r)
      LOW: begin
        if (s_s) begin
          if (FAST) begin
            state_next_s = HIGH;
            cnt_next_s   = CNT_ZERO;
            rise_s       = 1'b1;
          end else begin
            state_next_s = LOW_CHK;
            cnt_next_s   = CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      LOW_CHK: begin
        if (!s_s) begin
          state_next_s = LOW;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = HIGH;
          cnt_next_s   = CNT_ZERO;
          rise_s       = 1'b1;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      HIGH: begin
        if (!s_s) begin
          if (FAST) begin
            state_next_s = LOW;
            cnt_next_s   = CNT_ZERO;
            fall_s       = 1'b1;
          end else begin
            state_next_s = HIGH_CHK;
            cnt_next_s   = CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      HIGH_CHK: begin
        if (s_s) begin
          state_next_s = HIGH;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = LOW;
          cnt_next_s   = CNT_ZERO;
          fall_s       = 1'b1;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      default: begin
        state_next_s = LOW;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Auto-repeat timer: counts only while settled high, frozen in HIGH_CHK,
  // cleared by either accepted edge.
  always_comb begin
    rpt_next_s   = rpt_r;
    armed_next_s = armed_r;
    rep_pulse_s  = 1'b0;
    rpt_inc_s    = (rpt_r == RPT_ALL1) ? rpt_r : (rpt_r + RPT_ONE);
    rpt_target_s = armed_r ? RPT_RATE_V : RPT_DELAY_V;
    if (rise_s || fall_s) begin
      rpt_next_s   = RPT_ZERO;
      armed_next_s = 1'b0;
    end else if (REP_EN && (state_r == HIGH) && s_s) begin
      if (rpt_inc_s == rpt_target_s) begin
        rpt_next_s   = RPT_ZERO;
        armed_next_s = 1'b1;
        rep_pulse_s  = 1'b1;
      end else begin
        rpt_next_s = rpt_inc_s;
      end
    end else begin
      rpt_next_s = rpt_r;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    level_next_s     = (state_next_s == HIGH) || (state_next_s == HIGH_CHK);
    os_next_s        = (rise_s && PULSE_RISE) || (fall_s && PULSE_FALL) || rep_pulse_s;
    os_repeat_next_s = rep_pulse_s;
  end

  assign os        = os_r;
  assign level     = level_r;
  assign os_repeat = os_repeat_r;
  assign os_pre    = os_next_s;

endmodule

// File: rtl/debounce_oneshot_n.sv
// Multi-channel debounced one-shot: CHANNELS independent channels plus a
// registered OR of all pulses.
module debounce_oneshot_n
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] os,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] os_repeat,
  output logic                any_os
);

  logic [CHANNELS-1:0] os_pre_s;
  logic                any_os_r;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_MODE      (EDGE_MODE),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .in       (in[g]),
        .os       (os[g]),
        .level    (level[g]),
        .os_repeat(os_repeat[g]),
        .os_pre   (os_pre_s[g])
      );
    end
  endgenerate

  // Register the pulse summary on the same edge as the per-channel pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_os_r <= 1'b0;
    end else begin
      any_os_r <= |os_pre_s;
    end
  end

  assign any_os = any_os_r;

endmodule

// File: tb/tb_debounce_oneshot_n.sv
// Directed bench: three instances (rise-only, both edges, auto-repeat) with
// a per-phase vector table for the first and hand sequences for the others.
module tb_debounce_oneshot_n;

  logic       clk;
  logic       rst;
  logic [1:0] in_a, in_b, in_c;
  logic [1:0] os_a, os_b, os_c;
  logic [1:0] lvl_a, lvl_b, lvl_c;
  logic [1:0] rep_a, rep_b, rep_c;
  logic       any_a, any_b, any_c;

  int total = 0;
  int bad   = 0;

  debounce_oneshot_n #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                       .EDGE_MODE(0), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .os(os_a), .level(lvl_a),
    .os_repeat(rep_a), .any_os(any_a));

  debounce_oneshot_n #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                       .EDGE_MODE(2), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .os(os_b), .level(lvl_b),
    .os_repeat(rep_b), .any_os(any_b));

  debounce_oneshot_n #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                       .EDGE_MODE(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .os(os_c), .level(lvl_c),
    .os_repeat(rep_c), .any_os(any_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] in;
    int         hold;     // cycles this row is applied
    int         os_at;    // edge (1-based within row) where os is seen, 0 = never
    logic [1:0] os_bits;
    int         lvl_at;   // edge where level takes lvl_end, 0 = unchanged
    logic [1:0] lvl_end;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string what, input int k, input logic [1:0] act,
                       input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d: got %b want %b", what, k, act, exp);
    end
  endtask

  initial begin
    logic [1:0] cur_lvl;
    logic [1:0] exp_os;
    logic [1:0] exp_lvl;
    logic [1:0] exp_rep;

    vecs[0]  = '{"reset",      1'b1, 2'b00,  3, 0, 2'b00, 1, 2'b00};
    vecs[1]  = '{"press",      1'b0, 2'b01, 12, 6, 2'b01, 6, 2'b01};
    vecs[2]  = '{"release",    1'b0, 2'b00, 12, 0, 2'b00, 6, 2'b00};
    vecs[3]  = '{"glitch_hi",  1'b0, 2'b01,  3, 0, 2'b00, 0, 2'b00};
    vecs[4]  = '{"glitch_lo",  1'b0, 2'b00,  8, 0, 2'b00, 0, 2'b00};
    vecs[5]  = '{"pulse4_hi",  1'b0, 2'b01,  4, 0, 2'b00, 0, 2'b00};
    vecs[6]  = '{"pulse4_acc", 1'b0, 2'b00,  4, 2, 2'b01, 2, 2'b01};
    vecs[7]  = '{"pulse4_fall",1'b0, 2'b00,  8, 0, 2'b00, 2, 2'b00};
    vecs[8]  = '{"both",       1'b0, 2'b11, 10, 6, 2'b11, 6, 2'b11};
    vecs[9]  = '{"both_rel",   1'b0, 2'b00, 10, 0, 2'b00, 6, 2'b00};
    vecs[10] = '{"pre_rst",    1'b0, 2'b01,  3, 0, 2'b00, 0, 2'b00};
    vecs[11] = '{"mid_rst",    1'b1, 2'b01,  2, 0, 2'b00, 0, 2'b00};
    vecs[12] = '{"after_rst",  1'b0, 2'b01, 10, 6, 2'b01, 6, 2'b01};
    vecs[13] = '{"rst_high",   1'b1, 2'b01,  2, 0, 2'b00, 1, 2'b00};
    vecs[14] = '{"idle",       1'b0, 2'b00,  8, 0, 2'b00, 0, 2'b00};

    rst  = 1'b1;
    in_a = 2'b00;
    in_b = 2'b00;
    in_c = 2'b00;
    cur_lvl = 2'b00;

    // Table-driven phases on the rise-only instance.
    for (int r = 0; r < 15; r++) begin
      rst  = vecs[r].rst;
      in_a = vecs[r].in;
      for (int k = 1; k <= vecs[r].hold; k++) begin
        tick();
        exp_os  = (k == vecs[r].os_at) ? vecs[r].os_bits : 2'b00;
        exp_lvl = (vecs[r].lvl_at != 0 && k >= vecs[r].lvl_at) ? vecs[r].lvl_end : cur_lvl;
        check({vecs[r].name, " os"},    k, os_a,  exp_os);
        check({vecs[r].name, " level"}, k, lvl_a, exp_lvl);
        check({vecs[r].name, " rep"},   k, rep_a, 2'b00);
        check({vecs[r].name, " any"},   k, {1'b0, any_a}, {1'b0, |exp_os});
      end
      if (vecs[r].lvl_at != 0) cur_lvl = vecs[r].lvl_end;
    end
    rst = 1'b0;

    // Both-edge instance: press then release, each held 10 cycles.
    in_b = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_os = (k == 6) ? 2'b01 : 2'b00;
      check("b_press os",    k, os_b,  exp_os);
      check("b_press level", k, lvl_b, (k >= 6) ? 2'b01 : 2'b00);
      check("b_press any",   k, {1'b0, any_b}, {1'b0, |exp_os});
    end
    in_b = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_os = (k == 6) ? 2'b01 : 2'b00;
      check("b_release os",    k, os_b,  exp_os);
      check("b_release level", k, lvl_b, (k >= 6) ? 2'b00 : 2'b01);
      check("b_release rep",   k, rep_b, 2'b00);
    end

    // Auto-repeat instance: hold 22 cycles (pulses at 6,16,19,22), then release.
    in_c = 2'b01;
    for (int t = 1; t <= 36; t++) begin
      if (t == 23) in_c = 2'b00;
      tick();
      exp_os  = (t == 6 || t == 16 || t == 19 || t == 22) ? 2'b01 : 2'b00;
      exp_rep = (t == 16 || t == 19 || t == 22) ? 2'b01 : 2'b00;
      check("c_repeat os",     t, os_c,  exp_os);
      check("c_repeat os_rep", t, rep_c, exp_rep);
      check("c_repeat level",  t, lvl_c, (t >= 6 && t < 28) ? 2'b01 : 2'b00);
      check("c_repeat any",    t, {1'b0, any_c}, {1'b0, |exp_os});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
